// File: rtl/rob_pkg.sv
// Shared types for the multi-port reorder buffer: dispatch, CDB, retire and entry records.
package rob_pkg;

  localparam int ROB_XLEN      = 32;
  localparam int ROB_DEPTH     = 32;
  localparam int ROB_DP_WIDTH  = 2;
  localparam int ROB_CDB_WIDTH = 2;
  localparam int ROB_RT_WIDTH  = 2;
  // Tag fields in the records are sized for the largest supported ROB; the top uses the low TAG_W bits.
  localparam int ROB_TAG_MAXW  = 8;

  typedef struct packed {
    logic                has_dest;
    logic [4:0]          dest_reg;
    logic [ROB_XLEN-1:0] pc;
    logic [ROB_XLEN-1:0] npc;
  } rob_dp_t;

  typedef struct packed {
    logic                    valid;
    logic [ROB_TAG_MAXW-1:0] tag;
    logic [ROB_XLEN-1:0]     value;
    logic                    mispredict;
    logic [ROB_XLEN-1:0]     target_pc;
  } rob_cdb_t;

  typedef struct packed {
    logic                    has_dest;
    logic [4:0]              dest_reg;
    logic [ROB_XLEN-1:0]     value;
    logic [ROB_XLEN-1:0]     pc;
    logic [ROB_TAG_MAXW-1:0] tag;
  } rob_rt_t;

  // npc holds the fall-through PC until a mispredicting completion overwrites it with the target.
  typedef struct packed {
    logic                valid;
    logic                complete;
    logic                mispredict;
    logic                has_dest;
    logic [4:0]          dest_reg;
    logic [ROB_XLEN-1:0] value;
    logic [ROB_XLEN-1:0] pc;
    logic [ROB_XLEN-1:0] npc;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// In-order commit selection over the head window; a mispredicted entry commits and closes the window.
module rob_retire_sel #(
  parameter int RT_WIDTH = 2,
  parameter int CW       = $clog2(RT_WIDTH + 1),
  parameter int LW       = (RT_WIDTH > 1) ? $clog2(RT_WIDTH) : 1
) (
  input  logic [RT_WIDTH-1:0] ready,
  input  logic [RT_WIDTH-1:0] mispred,
  output logic [RT_WIDTH-1:0] commit,
  output logic [CW-1:0]       commit_cnt,
  output logic                squash,
  output logic [LW-1:0]       squash_lane
);

  logic go;

  always_comb begin
    go          = 1'b1;
    commit      = '0;
    commit_cnt  = '0;
    squash      = 1'b0;
    squash_lane = '0;
    for (int k = 0; k < RT_WIDTH; k++) begin
      if (go && ready[k]) begin
        commit[k]  = 1'b1;
        commit_cnt = commit_cnt + 1'b1;
        if (mispred[k]) begin
          squash      = 1'b1;
          squash_lane = LW'(k);
          go          = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Multi-issue reorder buffer: wide dispatch, multi-port CDB completion, in-order wide retire, squash at retire.
module rob_multiport
  import rob_pkg::*;
#(
  parameter int DEPTH     = ROB_DEPTH,
  parameter int DP_WIDTH  = ROB_DP_WIDTH,
  parameter int CDB_WIDTH = ROB_CDB_WIDTH,
  parameter int RT_WIDTH  = ROB_RT_WIDTH,
  parameter int XLEN      = ROB_XLEN,
  parameter int TAG_W     = $clog2(DEPTH)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic     [DP_WIDTH-1:0]              dp_valid,
  input  rob_dp_t  [DP_WIDTH-1:0]              dp_pkt,
  output logic                                 dp_ready,
  output logic     [DP_WIDTH-1:0][TAG_W-1:0]   dp_tag,
  output logic     [TAG_W:0]                   free_cnt,
  input  logic     [2*DP_WIDTH-1:0][TAG_W-1:0] src_tag,
  output logic     [2*DP_WIDTH-1:0]            src_ready,
  output logic     [2*DP_WIDTH-1:0][XLEN-1:0]  src_value,
  input  rob_cdb_t [CDB_WIDTH-1:0]             cdb,
  output logic     [RT_WIDTH-1:0]              rt_valid,
  output rob_rt_t  [RT_WIDTH-1:0]              rt_pkt,
  output logic                                 squash,
  output logic     [XLEN-1:0]                  squash_pc
);

  localparam int PW = TAG_W + 1;
  localparam int CW = $clog2(RT_WIDTH + 1);
  localparam int LW = (RT_WIDTH > 1) ? $clog2(RT_WIDTH) : 1;

  rob_entry_t        entries_q [DEPTH];
  rob_entry_t        entries_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, count, n_dp;
  logic [TAG_W-1:0]  win_idx [RT_WIDTH];
  logic [RT_WIDTH-1:0] win_ready, win_mispred, commit;
  logic [CW-1:0]     commit_cnt;
  logic              sq;
  logic [LW-1:0]     sq_lane;

  assign count    = tail_q - head_q;
  assign free_cnt = PW'(DEPTH) - count;
  assign dp_ready = free_cnt >= PW'(DP_WIDTH);

  always_comb begin
    for (int i = 0; i < DP_WIDTH; i++) dp_tag[i] = tail_q[TAG_W-1:0] + TAG_W'(i);
  end

  always_comb begin
    for (int k = 0; k < RT_WIDTH; k++) begin
      win_idx[k]          = head_q[TAG_W-1:0] + TAG_W'(k);
      win_ready[k]        = entries_q[win_idx[k]].valid & entries_q[win_idx[k]].complete;
      win_mispred[k]      = entries_q[win_idx[k]].mispredict;
      rt_pkt[k].has_dest  = entries_q[win_idx[k]].has_dest;
      rt_pkt[k].dest_reg  = entries_q[win_idx[k]].dest_reg;
      rt_pkt[k].value     = entries_q[win_idx[k]].value;
      rt_pkt[k].pc        = entries_q[win_idx[k]].pc;
      rt_pkt[k].tag       = ROB_TAG_MAXW'(win_idx[k]);
    end
  end

  rob_retire_sel #(.RT_WIDTH(RT_WIDTH), .CW(CW), .LW(LW)) u_retire_sel (
    .ready       (win_ready),
    .mispred     (win_mispred),
    .commit      (commit),
    .commit_cnt  (commit_cnt),
    .squash      (sq),
    .squash_lane (sq_lane)
  );

  assign rt_valid  = commit;
  assign squash    = sq;
  assign squash_pc = sq ? entries_q[win_idx[sq_lane]].npc : '0;

  // Operand lookup: iterate ports high to low so the lowest matching CDB port wins.
  always_comb begin
    for (int j = 0; j < 2*DP_WIDTH; j++) begin
      src_ready[j] = entries_q[src_tag[j]].complete;
      src_value[j] = entries_q[src_tag[j]].complete ? entries_q[src_tag[j]].value : '0;
      for (int p = CDB_WIDTH-1; p >= 0; p--) begin
        if (cdb[p].valid && (cdb[p].tag == ROB_TAG_MAXW'(src_tag[j]))) begin
          src_ready[j] = 1'b1;
          src_value[j] = cdb[p].value;
        end
      end
    end
  end

  always_comb begin
    entries_d = entries_q;
    n_dp      = '0;
    for (int p = 0; p < CDB_WIDTH; p++) begin
      if (cdb[p].valid && entries_q[cdb[p].tag[TAG_W-1:0]].valid) begin
        entries_d[cdb[p].tag[TAG_W-1:0]].value      = cdb[p].value;
        entries_d[cdb[p].tag[TAG_W-1:0]].complete   = 1'b1;
        entries_d[cdb[p].tag[TAG_W-1:0]].mispredict = cdb[p].mispredict;
        if (cdb[p].mispredict) entries_d[cdb[p].tag[TAG_W-1:0]].npc = cdb[p].target_pc;
      end
    end
    for (int k = 0; k < RT_WIDTH; k++) begin
      if (commit[k]) entries_d[win_idx[k]].valid = 1'b0;
    end
    for (int i = 0; i < DP_WIDTH; i++) begin
      if (dp_ready && dp_valid[i]) begin
        entries_d[dp_tag[i]].valid      = 1'b1;
        entries_d[dp_tag[i]].complete   = 1'b0;
        entries_d[dp_tag[i]].mispredict = 1'b0;
        entries_d[dp_tag[i]].has_dest   = dp_pkt[i].has_dest;
        entries_d[dp_tag[i]].dest_reg   = dp_pkt[i].dest_reg;
        entries_d[dp_tag[i]].value      = '0;
        entries_d[dp_tag[i]].pc         = dp_pkt[i].pc;
        entries_d[dp_tag[i]].npc        = dp_pkt[i].npc;
        n_dp = n_dp + 1'b1;
      end
    end
    head_d = head_q + PW'(commit_cnt);
    tail_d = tail_q + n_dp;
    // A retiring mispredict empties the buffer; everything written above this cycle is dropped with it.
    if (sq) begin
      tail_d = head_d;
      for (int e = 0; e < DEPTH; e++) begin
        entries_d[e]       = entries_q[e];
        entries_d[e].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      for (int e = 0; e < DEPTH; e++) entries_q[e] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int e = 0; e < DEPTH; e++) entries_q[e] <= entries_d[e];
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport at DEPTH=8, two lanes everywhere.
module tb_rob_multiport;
  import rob_pkg::*;

  logic                  clock, reset;
  logic     [1:0]        dp_valid;
  rob_dp_t  [1:0]        dp_pkt;
  logic                  dp_ready;
  logic     [1:0][2:0]   dp_tag;
  logic     [3:0]        free_cnt;
  logic     [3:0][2:0]   src_tag;
  logic     [3:0]        src_ready;
  logic     [3:0][31:0]  src_value;
  rob_cdb_t [1:0]        cdb;
  logic     [1:0]        rt_valid;
  rob_rt_t  [1:0]        rt_pkt;
  logic                  squash;
  logic     [31:0]       squash_pc;

  int n_cmp = 0;
  int n_bad = 0;

  rob_multiport #(.DEPTH(8), .DP_WIDTH(2), .CDB_WIDTH(2), .RT_WIDTH(2), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .dp_valid(dp_valid), .dp_pkt(dp_pkt), .dp_ready(dp_ready),
    .dp_tag(dp_tag), .free_cnt(free_cnt), .src_tag(src_tag), .src_ready(src_ready),
    .src_value(src_value), .cdb(cdb), .rt_valid(rt_valid), .rt_pkt(rt_pkt),
    .squash(squash), .squash_pc(squash_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clock) begin
    if (!reset) begin
      if ((|dp_valid) && !dp_ready) $error("illegal dispatch while not ready");
      if (dp_valid == 2'b10) $error("non-contiguous dispatch lanes");
      if (cdb[0].valid && cdb[1].valid && cdb[0].tag == cdb[1].tag) $error("duplicate cdb tags");
    end
  end

  task automatic idle();
    dp_valid = '0;
    dp_pkt   = '0;
    cdb      = '0;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    src_tag = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Lane packets carry a payload derived from the sequence index so retire data can be traced.
  task automatic set_dispatch(input int base);
    dp_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      dp_pkt[i].has_dest = 1'b1;
      dp_pkt[i].dest_reg = 5'(base + i + 1);
      dp_pkt[i].pc       = 32'h1000 + 32'(4 * (base + i));
      dp_pkt[i].npc      = 32'h1004 + 32'(4 * (base + i));
    end
  endtask

  task automatic set_cdb(input int port, input int tag, input logic [31:0] value,
                         input logic mis, input logic [31:0] target);
    cdb[port].valid      = 1'b1;
    cdb[port].tag        = ROB_TAG_MAXW'(tag);
    cdb[port].value      = value;
    cdb[port].mispredict = mis;
    cdb[port].target_pc  = target;
  endtask

  task automatic fill();
    for (int c = 0; c < 4; c++) begin
      set_dispatch(2 * c);
      #1;
      n_cmp++; if (dp_tag[0] !== 3'(2*c)) begin n_bad++; $display("FAIL fill_tag0: got %0d expected %0d", dp_tag[0], 2*c); end
      n_cmp++; if (dp_tag[1] !== 3'(2*c+1)) begin n_bad++; $display("FAIL fill_tag1: got %0d expected %0d", dp_tag[1], 2*c+1); end
      step();
      idle();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (dp_ready !== 1'b1) begin n_bad++; $display("FAIL reset_dp_ready: got %0d expected 1", dp_ready); end
    n_cmp++; if (free_cnt !== 4'd8) begin n_bad++; $display("FAIL reset_free_cnt: got %0d expected 8", free_cnt); end
    n_cmp++; if (rt_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rt_valid: got %b expected 00", rt_valid); end
    n_cmp++; if (squash !== 1'b0) begin n_bad++; $display("FAIL reset_squash: got %0d expected 0", squash); end
    n_cmp++; if (squash_pc !== 32'h0) begin n_bad++; $display("FAIL reset_squash_pc: got %0h expected 0", squash_pc); end
    n_cmp++; if (src_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_src_ready: got %b expected 0000", src_ready); end
    n_cmp++; if (dp_tag !== {3'd1, 3'd0}) begin n_bad++; $display("FAIL reset_dp_tag: got %h expected %h", dp_tag, {3'd1, 3'd0}); end
  endtask

  task automatic test_fill();
    fill();
    #1;
    n_cmp++; if (dp_ready !== 1'b0) begin n_bad++; $display("FAIL full_dp_ready: got %0d expected 0", dp_ready); end
    n_cmp++; if (free_cnt !== 4'd0) begin n_bad++; $display("FAIL full_free_cnt: got %0d expected 0", free_cnt); end
    step();
    #1;
    n_cmp++; if (free_cnt !== 4'd0) begin n_bad++; $display("FAIL full_hold_free_cnt: got %0d expected 0", free_cnt); end
    n_cmp++; if (rt_valid !== 2'b00) begin n_bad++; $display("FAIL full_rt_valid: got %b expected 00", rt_valid); end
  endtask

  task automatic test_out_of_order();
    set_cdb(0, 1, 32'h101, 1'b0, 32'h0);
    set_cdb(1, 0, 32'h100, 1'b0, 32'h0);
    #1;
    n_cmp++; if (rt_valid !== 2'b00) begin n_bad++; $display("FAIL ooo_same_cycle_rt: got %b expected 00", rt_valid); end
    step();
    idle();
    #1;
    n_cmp++; if (rt_valid !== 2'b11) begin n_bad++; $display("FAIL ooo_rt_valid: got %b expected 11", rt_valid); end
    n_cmp++; if (rt_pkt[0].tag !== 8'd0) begin n_bad++; $display("FAIL ooo_rt_tag0: got %0d expected 0", rt_pkt[0].tag); end
    n_cmp++; if (rt_pkt[1].tag !== 8'd1) begin n_bad++; $display("FAIL ooo_rt_tag1: got %0d expected 1", rt_pkt[1].tag); end
    n_cmp++; if (rt_pkt[0].value !== 32'h100) begin n_bad++; $display("FAIL ooo_rt_value0: got %0h expected 100", rt_pkt[0].value); end
    n_cmp++; if (rt_pkt[1].value !== 32'h101) begin n_bad++; $display("FAIL ooo_rt_value1: got %0h expected 101", rt_pkt[1].value); end
    n_cmp++; if (rt_pkt[1].pc !== 32'h1004) begin n_bad++; $display("FAIL ooo_rt_pc1: got %0h expected 1004", rt_pkt[1].pc); end
    n_cmp++; if (rt_pkt[1].dest_reg !== 5'd2) begin n_bad++; $display("FAIL ooo_rt_dest1: got %0d expected 2", rt_pkt[1].dest_reg); end
    n_cmp++; if (free_cnt !== 4'd0) begin n_bad++; $display("FAIL ooo_pre_retire_free: got %0d expected 0", free_cnt); end
    step();
    #1;
    n_cmp++; if (free_cnt !== 4'd2) begin n_bad++; $display("FAIL ooo_free_cnt: got %0d expected 2", free_cnt); end
    n_cmp++; if (dp_ready !== 1'b1) begin n_bad++; $display("FAIL ooo_dp_ready: got %0d expected 1", dp_ready); end
  endtask

  task automatic test_partial();
    set_cdb(0, 3, 32'h103, 1'b0, 32'h0);
    step();
    idle();
    #1;
    n_cmp++; if (rt_valid !== 2'b00) begin n_bad++; $display("FAIL partial_wait1: got %b expected 00", rt_valid); end
    step();
    #1;
    n_cmp++; if (rt_valid !== 2'b00) begin n_bad++; $display("FAIL partial_wait2: got %b expected 00", rt_valid); end
    set_cdb(1, 2, 32'h102, 1'b0, 32'h0);
    step();
    idle();
    #1;
    n_cmp++; if (rt_valid !== 2'b11) begin n_bad++; $display("FAIL partial_rt_valid: got %b expected 11", rt_valid); end
    n_cmp++; if (rt_pkt[0].tag !== 8'd2) begin n_bad++; $display("FAIL partial_rt_tag0: got %0d expected 2", rt_pkt[0].tag); end
    n_cmp++; if (rt_pkt[1].value !== 32'h103) begin n_bad++; $display("FAIL partial_rt_value1: got %0h expected 103", rt_pkt[1].value); end
    step();
    #1;
    n_cmp++; if (free_cnt !== 4'd4) begin n_bad++; $display("FAIL partial_free_cnt: got %0d expected 4", free_cnt); end
  endtask

  task automatic test_mispredict();
    do_reset();
    fill();
    set_cdb(0, 0, 32'h100, 1'b0, 32'h0);
    set_cdb(1, 1, 32'h101, 1'b0, 32'h0);
    step();
    idle();
    step();
    set_cdb(0, 2, 32'h102, 1'b1, 32'h80);
    set_cdb(1, 3, 32'h103, 1'b0, 32'h0);
    step();
    idle();
    set_dispatch(8);
    set_cdb(0, 4, 32'h104, 1'b0, 32'h0);
    #1;
    n_cmp++; if (rt_valid !== 2'b01) begin n_bad++; $display("FAIL mis_rt_valid: got %b expected 01", rt_valid); end
    n_cmp++; if (rt_pkt[0].tag !== 8'd2) begin n_bad++; $display("FAIL mis_rt_tag: got %0d expected 2", rt_pkt[0].tag); end
    n_cmp++; if (squash !== 1'b1) begin n_bad++; $display("FAIL mis_squash: got %0d expected 1", squash); end
    n_cmp++; if (squash_pc !== 32'h80) begin n_bad++; $display("FAIL mis_squash_pc: got %0h expected 80", squash_pc); end
    n_cmp++; if (free_cnt !== 4'd2) begin n_bad++; $display("FAIL mis_free_pre: got %0d expected 2", free_cnt); end
    step();
    idle();
    src_tag[0] = 3'd4;
    #1;
    n_cmp++; if (free_cnt !== 4'd8) begin n_bad++; $display("FAIL mis_free_after: got %0d expected 8", free_cnt); end
    n_cmp++; if (rt_valid !== 2'b00) begin n_bad++; $display("FAIL mis_rt_after: got %b expected 00", rt_valid); end
    n_cmp++; if (squash !== 1'b0) begin n_bad++; $display("FAIL mis_squash_after: got %0d expected 0", squash); end
    n_cmp++; if (squash_pc !== 32'h0) begin n_bad++; $display("FAIL mis_squash_pc_after: got %0h expected 0", squash_pc); end
    n_cmp++; if (dp_tag !== {3'd4, 3'd3}) begin n_bad++; $display("FAIL mis_dp_tag: got %h expected %h", dp_tag, {3'd4, 3'd3}); end
    n_cmp++; if (src_ready[0] !== 1'b0) begin n_bad++; $display("FAIL mis_cdb_discard: got %0d expected 0", src_ready[0]); end
    step();
    #1;
    n_cmp++; if (rt_valid !== 2'b00) begin n_bad++; $display("FAIL mis_tag3_stays: got %b expected 00", rt_valid); end
  endtask

  task automatic test_forward();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_dispatch(2 * c);
      step();
      idle();
    end
    src_tag[0] = 3'd5;
    src_tag[1] = 3'd4;
    set_cdb(1, 5, 32'hDEAD, 1'b0, 32'h0);
    #1;
    n_cmp++; if (src_ready[0] !== 1'b1) begin n_bad++; $display("FAIL fwd_ready: got %0d expected 1", src_ready[0]); end
    n_cmp++; if (src_value[0] !== 32'hDEAD) begin n_bad++; $display("FAIL fwd_value: got %0h expected dead", src_value[0]); end
    n_cmp++; if (src_ready[1] !== 1'b0) begin n_bad++; $display("FAIL fwd_other_ready: got %0d expected 0", src_ready[1]); end
    n_cmp++; if (src_value[1] !== 32'h0) begin n_bad++; $display("FAIL fwd_other_value: got %0h expected 0", src_value[1]); end
    step();
    idle();
    #1;
    n_cmp++; if (src_ready[0] !== 1'b1) begin n_bad++; $display("FAIL fwd_stored_ready: got %0d expected 1", src_ready[0]); end
    n_cmp++; if (src_value[0] !== 32'hDEAD) begin n_bad++; $display("FAIL fwd_stored_value: got %0h expected dead", src_value[0]); end
  endtask

  task automatic test_back_to_back();
    int exp_free;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      set_dispatch(2 * c);
      if (c >= 1) begin
        set_cdb(0, (2*c-2) % 8, 32'h5000 + 32'(2*c-2), 1'b0, 32'h0);
        set_cdb(1, (2*c-1) % 8, 32'h5000 + 32'(2*c-1), 1'b0, 32'h0);
      end
      exp_free = (c == 0) ? 8 : (c == 1) ? 6 : 4;
      #1;
      n_cmp++; if (dp_tag[0] !== 3'((2*c) % 8)) begin n_bad++; $display("FAIL b2b_tag0 c=%0d: got %0d expected %0d", c, dp_tag[0], (2*c) % 8); end
      n_cmp++; if (dp_tag[1] !== 3'((2*c+1) % 8)) begin n_bad++; $display("FAIL b2b_tag1 c=%0d: got %0d expected %0d", c, dp_tag[1], (2*c+1) % 8); end
      n_cmp++; if (free_cnt !== 4'(exp_free)) begin n_bad++; $display("FAIL b2b_free c=%0d: got %0d expected %0d", c, free_cnt, exp_free); end
      n_cmp++; if (rt_valid !== ((c >= 2) ? 2'b11 : 2'b00)) begin n_bad++; $display("FAIL b2b_rt_valid c=%0d: got %b expected %b", c, rt_valid, (c >= 2) ? 2'b11 : 2'b00); end
      if (c >= 2) begin
        n_cmp++; if (rt_pkt[0].tag !== 8'((2*c-4) % 8)) begin n_bad++; $display("FAIL b2b_rt_tag0 c=%0d: got %0d expected %0d", c, rt_pkt[0].tag, (2*c-4) % 8); end
        n_cmp++; if (rt_pkt[1].value !== 32'h5000 + 32'(2*c-3)) begin n_bad++; $display("FAIL b2b_rt_value1 c=%0d: got %0h expected %0h", c, rt_pkt[1].value, 32'h5000 + 32'(2*c-3)); end
      end
      step();
      idle();
    end
    reset = 1'b1;
    set_dispatch(40);
    set_cdb(0, 6, 32'h5026, 1'b0, 32'h0);
    set_cdb(1, 7, 32'h5027, 1'b0, 32'h0);
    step();
    idle();
    reset = 1'b0;
    #1;
    n_cmp++; if (free_cnt !== 4'd8) begin n_bad++; $display("FAIL midrst_free: got %0d expected 8", free_cnt); end
    n_cmp++; if (dp_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_dp_ready: got %0d expected 1", dp_ready); end
    n_cmp++; if (rt_valid !== 2'b00) begin n_bad++; $display("FAIL midrst_rt_valid: got %b expected 00", rt_valid); end
    n_cmp++; if (squash !== 1'b0) begin n_bad++; $display("FAIL midrst_squash: got %0d expected 0", squash); end
    n_cmp++; if (dp_tag !== {3'd1, 3'd0}) begin n_bad++; $display("FAIL midrst_dp_tag: got %h expected %h", dp_tag, {3'd1, 3'd0}); end
  endtask

  initial begin
    reset   = 1'b1;
    src_tag = '0;
    idle();
    @(negedge clock);
    test_reset();
    test_fill();
    test_out_of_order();
    test_partial();
    test_mispredict();
    test_forward();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_multiport.md
# rob_multiport

Parametrised multi-issue reorder buffer: allocates up to DP_WIDTH entries per cycle at dispatch, accepts up to CDB_WIDTH completions per cycle, retires up to RT_WIDTH in-order completed entries per cycle, and performs precise branch-mispredict recovery at retire. It sits between dispatch/map-table (allocation and operand lookup), the CDB (completion), and the retire stage / architectural register file (commit and squash broadcast).

## Interface
- DEPTH, 32, number of entries; power of 2, ≥ DP_WIDTH
- DP_WIDTH, 2, dispatch lanes
- CDB_WIDTH, 2, completion ports
- RT_WIDTH, 2, retire lanes
- XLEN, 32, value/PC width
- TAG_W, $clog2(DEPTH), entry tag width
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- dp_valid  in  DP_WIDTH  per-lane allocate request; lanes contiguous from lane 0
- dp_pkt  in  DP_WIDTH×rob_dp_t  {has_dest, dest_reg[4:0], PC, NPC}
- dp_ready  out  1  free entries ≥ DP_WIDTH
- dp_tag  out  DP_WIDTH×TAG_W  tag assigned to each lane this cycle
- free_cnt  out  $clog2(DEPTH)+1  free entries
- src_tag  in  2·DP_WIDTH×TAG_W  operand lookup tags (rs1/rs2 per lane)
- src_ready  out  2·DP_WIDTH  operand value available
- src_value  out  2·DP_WIDTH×XLEN  operand value (0 when not ready)
- cdb  in  CDB_WIDTH×rob_cdb_t  {valid, tag, value, mispredict, target_pc}
- rt_valid  out  RT_WIDTH  lane commits this cycle
- rt_pkt  out  RT_WIDTH×rob_rt_t  {has_dest, dest_reg, value, PC, tag}
- squash  out  1  mispredict retired this cycle
- squash_pc  out  XLEN  redirect target

## Operation
- Entry state: valid, complete, mispredict, has_dest, dest_reg, value, PC, NPC/target.
- head/tail are TAG_W+1 bits; MSB is wrap bit. count = tail−head (mod 2^(TAG_W+1)); empty when equal; full when count = DEPTH.
- Dispatch: when dp_ready, lane i with dp_valid[i] writes entry tail+i, clears complete/mispredict, sets valid; tail advances by popcount(dp_valid). dp_tag[i] = tail+i regardless of dp_valid. dp_valid with dp_ready=0, or non-contiguous lanes: illegal (bench assertion).
- Complete: each valid cdb port writes value, complete=1, mispredict, target_pc into entry tag. Tags across ports are unique within a cycle (assertion). Writes to invalid entries are ignored.
- Operand lookup: src_ready = entry complete, or any valid cdb port matching tag this cycle (CDB forwarded; lowest port wins if ever duplicated).
- Retire: lane k commits entry head+k if entries head..head+k are all valid and complete and none of head..head+k−1 is mispredicted. A mispredicted entry commits itself and stops further lanes. head advances by number committed; committed entries' valid cleared.
- Squash: when a committing entry has mispredict=1: squash=1, squash_pc=its target_pc; next state is empty (tail←new head), all valid bits cleared; that cycle's dispatch and CDB writes are discarded.

## Timing
- Reset: head=tail=0, all entries invalid; dp_ready=1, free_cnt=DEPTH, rt_valid=0, squash=0, squash_pc=0, src_ready=0 unless CDB forwarding.
- rt_*, squash, dp_ready, free_cnt, dp_tag: combinational from registered state only (no cdb→retire path). Entry completed via CDB in cycle n retires no earlier than n+1.
- src_*: combinational from state plus cdb.
- Allocated in cycle n: visible to CDB write and lookup from n+1.
- dp_ready uses pre-retire count (entries freed in cycle n usable in n+1).
- Wrap-around: tags modulo DEPTH; full vs empty distinguished by wrap bit.
- Reset mid-operation overrides squash, dispatch, CDB.

## Structure
- rob_pkg: rob_dp_t, rob_cdb_t, rob_rt_t, rob_entry_t typedefs; ROB defaults.
- Sub-module rob_retire_sel: combinational, takes RT_WIDTH head-window entry states, returns rt_valid mask, commit count, squash lane.
- Top: entry array, pointers, dispatch write, CDB write, lookup muxes.

## Test plan
- DEPTH=8, DP=2: dispatch 4 cycles of 2 → tags 0..7, dp_ready=0 and free_cnt=0 after 4th; no further allocation.
- Complete tags 1 then 0 on CDB ports 0/1 same cycle → next cycle rt_valid=2'b11 tags 0,1; free_cnt=2.
- Complete tag 3 only, head=2 → rt_valid=0 until tag 2 completes; then tags 2,3 retire together.
- Tag 2 mispredict target 0x80, tags 2,3 complete → rt_valid=2'b01 (tag 2 only), squash=1, squash_pc=0x80; next cycle empty, free_cnt=8, tag 3 never retires.
- Lookup tag 5 while CDB port 1 writes tag 5 value 0xDEAD → src_ready=1, src_value=0xDEAD same cycle.
- 20 cycles of continuous 2-wide dispatch/complete/retire → tags wrap 7→0, count never exceeds 8, reset mid-stream → all outputs to reset values next cycle.
